// File: rtl/link_stack_ctrl.sv
// Call/return sequencer: pushes LR on CALL, pops it on RET, and drives the
// special register file's SP/LR/PC write channels plus one data-memory port.
module link_stack_ctrl #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [31:0] call_target,
    input  logic [31:0] pc_in,
    input  logic [31:0] lr_in,
    input  logic [31:0] sp_in,
    output logic        wr_pc,
    output logic [31:0] wr_pc_data,
    output logic        wr_lr,
    output logic [31:0] wr_lr_data,
    output logic        wr_sp,
    output logic [31:0] wr_sp_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_CALL_UPD,
        S_POP,
        S_RET_UPD,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     pc_l;
    logic [31:0]     lr_l;
    logic [31:0]     sp_l;
    logic [31:0]     target_l;
    logic [31:0]     pop_l;
    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;

    // Last tolerated wait cycle; a ready on this same cycle still wins.
    assign timeout_hit = (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (call_req) begin
                    state_nxt = ((sp_in - 32'd4) < STACK_LIMIT) ? S_FAULT : S_PUSH;
                end else if (ret_req) begin
                    state_nxt = (sp_in >= STACK_BASE) ? S_FAULT : S_POP;
                end
            end
            S_PUSH: begin
                if (mem_ready)        state_nxt = S_CALL_UPD;
                else if (timeout_hit) state_nxt = S_FAULT;
            end
            S_POP: begin
                if (mem_ready)        state_nxt = S_RET_UPD;
                else if (timeout_hit) state_nxt = S_FAULT;
            end
            S_CALL_UPD,
            S_RET_UPD,
            S_FAULT:                  state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: operand registers are reset too, so every output bus reads 0 during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_l     <= '0;
            lr_l     <= '0;
            sp_l     <= '0;
            target_l <= '0;
            pop_l    <= '0;
        end else begin
            if (state == S_IDLE && (call_req || ret_req)) begin
                pc_l     <= pc_in;
                lr_l     <= lr_in;
                sp_l     <= sp_in;
                target_l <= call_target;
            end
            if (state == S_POP && mem_ready) begin
                pop_l <= mem_rdata;
            end
        end
    end

    // Counter sits at zero outside the memory states, so it is clear on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_PUSH || state == S_POP) begin
            if (!mem_ready) wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_comb begin
        wr_pc      = 1'b0;
        wr_pc_data = '0;
        wr_lr      = 1'b0;
        wr_lr_data = '0;
        wr_sp      = 1'b0;
        wr_sp_data = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        fault      = 1'b0;
        unique case (state)
            S_PUSH: begin
                mem_we    = 1'b1;
                mem_addr  = sp_l - 32'd4;
                mem_wdata = lr_l;
            end
            S_CALL_UPD: begin
                wr_sp      = 1'b1;
                wr_sp_data = sp_l - 32'd4;
                wr_lr      = 1'b1;
                wr_lr_data = pc_l + 32'd4;
                wr_pc      = 1'b1;
                wr_pc_data = target_l;
                done       = 1'b1;
            end
            S_POP: begin
                mem_re   = 1'b1;
                mem_addr = sp_l;
            end
            S_RET_UPD: begin
                wr_pc      = 1'b1;
                wr_pc_data = lr_l;
                wr_lr      = 1'b1;
                wr_lr_data = pop_l;
                wr_sp      = 1'b1;
                wr_sp_data = sp_l + 32'd4;
                done       = 1'b1;
            end
            S_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_link_stack_ctrl.sv
// Randomized bench for link_stack_ctrl: each CALL/RET is predicted as a whole
// transaction (fault/timeout/success, memory cycles, final writes) and compared.
module tb_link_stack_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] LIMIT = 32'h0000_0800;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        call_req, ret_req;
    logic [31:0] call_target, pc_in, lr_in, sp_in;
    logic        wr_pc, wr_lr, wr_sp;
    logic [31:0] wr_pc_data, wr_lr_data, wr_sp_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ready;
    logic        busy, done, fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    link_stack_ctrl dut (
        .clk(clk), .reset(reset),
        .call_req(call_req), .ret_req(ret_req), .call_target(call_target),
        .pc_in(pc_in), .lr_in(lr_in), .sp_in(sp_in),
        .wr_pc(wr_pc), .wr_pc_data(wr_pc_data),
        .wr_lr(wr_lr), .wr_lr_data(wr_lr_data),
        .wr_sp(wr_sp), .wr_sp_data(wr_sp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. waits = number of not-ready
    // memory cycles before ready; waits >= TMO means memory never answers in time.
    task automatic run_txn(input bit do_call, input bit do_ret,
                           input logic [31:0] pc, input logic [31:0] lr,
                           input logic [31:0] sp, input logic [31:0] tgt,
                           input int waits, input logic [31:0] rdata, input bit noisy);
        bit          is_call = do_call;
        bit          pre_fault;
        bit          exp_fault;
        int          exp_mem;
        int          exp_busy;
        logic [31:0] exp_addr, exp_pc, exp_lr, exp_sp;
        int          cyc = 0, memc = 0, busy_n = 0, we_n = 0, re_n = 0;
        int          done_n = 0, fault_n = 0, term_at = -1;
        bit          finished = 0;
        bit          mem_act;

        if (is_call) begin
            pre_fault = ((sp - 32'd4) < LIMIT);
            exp_addr  = sp - 32'd4;
            exp_sp    = sp - 32'd4;
            exp_lr    = pc + 32'd4;
            exp_pc    = tgt;
        end else begin
            pre_fault = (sp >= BASE);
            exp_addr  = sp;
            exp_sp    = sp + 32'd4;
            exp_lr    = rdata;
            exp_pc    = lr;
        end
        exp_mem   = pre_fault ? 0 : ((waits >= TMO) ? TMO : waits + 1);
        exp_fault = pre_fault || (waits >= TMO);
        exp_busy  = exp_mem + 1;

        call_req    = do_call;
        ret_req     = do_ret;
        pc_in       = pc;
        lr_in       = lr;
        sp_in       = sp;
        call_target = tgt;
        mem_ready   = 1'b0;
        @(posedge clk);

        while (!finished && cyc < 60) begin
            @(negedge clk);
            mem_act = mem_we || mem_re;
            if (!busy) begin
                finished = 1;
            end else begin
                busy_n++;
                check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
                check("done_fault_exclusive", 32'(done & fault), 32'd0);
                check("wr_strobes", 32'({wr_pc, wr_lr, wr_sp}), done ? 32'd7 : 32'd0);
                if (mem_we) we_n++;
                if (mem_re) re_n++;
                if (mem_act) check("mem_addr", mem_addr, exp_addr);
                if (mem_we) check("mem_wdata", mem_wdata, lr);
                if (done) begin
                    done_n++;
                    term_at = busy_n;
                    check("wr_pc_data", wr_pc_data, exp_pc);
                    check("wr_lr_data", wr_lr_data, exp_lr);
                    check("wr_sp_data", wr_sp_data, exp_sp);
                end
                if (fault) begin
                    fault_n++;
                    term_at = busy_n;
                end
            end
            mem_ready = mem_act && (memc == waits);
            mem_rdata = mem_ready ? rdata : $urandom;
            if (mem_act) memc++;
            if (noisy && busy) begin
                call_req    = 1'($urandom_range(0, 1));
                ret_req     = 1'($urandom_range(0, 1));
                pc_in       = $urandom;
                lr_in       = $urandom;
                sp_in       = $urandom;
                call_target = $urandom;
            end else begin
                call_req = 1'b0;
                ret_req  = 1'b0;
            end
            cyc++;
        end
        mem_ready = 1'b0;

        if (!finished) check("cycle_bound", 32'd0, 32'd1);
        check("busy_cycles", busy_n, exp_busy);
        check("we_cycles", we_n, (is_call && !pre_fault) ? exp_mem : 0);
        check("re_cycles", re_n, (!is_call && !pre_fault) ? exp_mem : 0);
        check("done_count", done_n, exp_fault ? 0 : 1);
        check("fault_count", fault_n, exp_fault ? 1 : 0);
        check("terminal_cycle", term_at, exp_busy);
    endtask

    initial begin
        logic [31:0] sp_r;
        int          kind, waits;

        reset       = 1'b1;
        call_req    = 1'b0;
        ret_req     = 1'b0;
        call_target = '0;
        pc_in       = '0;
        lr_in       = '0;
        sp_in       = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 32'({wr_pc, wr_lr, wr_sp, mem_we, mem_re, busy, done, fault}), 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_wr_data", wr_pc_data | wr_lr_data | wr_sp_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan.
        run_txn(1, 0, 32'h100, 32'h44, 32'h1000, 32'h200, 0, 32'h0, 0);
        run_txn(0, 1, 32'h300, 32'h104, 32'hFFC, 32'h0, 3, 32'h44, 0);
        run_txn(1, 0, 32'h100, 32'h44, 32'h800, 32'h200, 0, 32'h0, 0);
        run_txn(0, 1, 32'h100, 32'h44, 32'h1000, 32'h200, 0, 32'h0, 0);
        run_txn(1, 0, 32'h100, 32'h44, 32'h1000, 32'h200, 99, 32'h0, 0);
        run_txn(0, 1, 32'h100, 32'h44, 32'hF00, 32'h200, 15, 32'hABCD, 0);
        run_txn(1, 1, 32'h120, 32'h48, 32'hF00, 32'h400, 1, 32'h0, 1);
        run_txn(0, 1, 32'h120, 32'h48, 32'hF00, 32'h400, 2, 32'h1234, 1);

        // Asynchronous reset in the middle of a POP.
        call_req = 1'b0;
        ret_req  = 1'b1;
        sp_in    = 32'hFF0;
        lr_in    = 32'h88;
        @(posedge clk);
        @(negedge clk);
        ret_req = 1'b0;
        check("pop_active", 32'({mem_re, busy}), 32'd3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({wr_pc, wr_lr, wr_sp, mem_we, mem_re, busy, done, fault}), 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'd0);
        run_txn(0, 1, 32'h0, 32'h88, 32'hFF0, 32'h0, 1, 32'h5555, 0);

        // Randomized mix, biased toward the stack boundaries and the timeout edge.
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 5))
                0:       sp_r = LIMIT;
                1:       sp_r = LIMIT + 32'd4;
                2:       sp_r = BASE;
                3:       sp_r = BASE - 32'd4;
                4:       sp_r = 32'($urandom_range(32'h200, 32'h400)) << 2;
                default: sp_r = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       waits = TMO;
                1:       waits = TMO - 1;
                default: waits = $urandom_range(0, 4);
            endcase
            run_txn(kind != 1, kind != 0, $urandom, $urandom, sp_r, $urandom,
                    waits, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/link_stack_ctrl.md
Name: link_stack_ctrl

Overview:
- Multi-cycle call/return sequencer that initiates writes into the special register file's dedicated SP, LR and PC write channels.
- On CALL it pushes the current LR to data memory, then updates SP, LR and PC.
- On RET it restores PC from LR, pops the saved LR from memory, and updates SP.
- Sits between the control unit (requests) and the special register file (re_* values in, wr_* strobes out) plus the data-memory port.

Parameters:
- STACK_BASE, 32'h0000_1000: empty-stack SP value; RET with SP >= STACK_BASE faults.
- STACK_LIMIT, 32'h0000_0800: lowest legal SP; CALL whose new SP < STACK_LIMIT faults.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready before fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  1  start CALL, sampled in IDLE only.
- ret_req  in  1  start RET, sampled in IDLE only.
- call_target  in  32  branch target for CALL.
- pc_in  in  32  current PC, from re_pc.
- lr_in  in  32  current LR, from re_lr.
- sp_in  in  32  current SP, from re_sp.
- wr_pc  out  1  PC write strobe.
- wr_pc_data  out  32  PC write data.
- wr_lr  out  1  LR write strobe.
- wr_lr_data  out  32  LR write data.
- wr_sp  out  1  SP write strobe.
- wr_sp_data  out  32  SP write data.
- mem_addr  out  32  word-aligned data-memory address.
- mem_wdata  out  32  push data.
- mem_we  out  1  memory write request.
- mem_re  out  1  memory read request.
- mem_ready  in  1  memory completion, one cycle.
- mem_rdata  in  32  pop data, valid while mem_ready=1.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on successful completion.
- fault  out  1  one-cycle pulse on overflow, underflow or timeout.

Behaviour:
- Reset (async, reset=1):
  - State goes to IDLE.
  - All outputs go to 0, including data/address buses; the timeout counter clears.
  - Reset mid-operation drops any outstanding memory request immediately and issues no register writes.
- State outputs: all outputs are registered/Moore-style, decoded from state and latched operands.
- States: IDLE, PUSH, CALL_UPD, POP, RET_UPD, FAULT.
- IDLE:
  - On the edge where call_req=1, latch pc_in, lr_in, sp_in, call_target.
    - If sp_in-4 < STACK_LIMIT (unsigned), go to FAULT.
    - Otherwise go to PUSH.
  - Else, on ret_req=1, latch the same operands.
    - If sp_in >= STACK_BASE, go to FAULT.
    - Otherwise go to POP.
  - call_req has priority when both are high; that ret_req is dropped, not queued.
  - Requests outside IDLE are ignored.
- PUSH:
  - Drives mem_we=1, mem_addr=sp_l-4, mem_wdata=lr_l.
  - Stays until mem_ready=1 is sampled, then goes to CALL_UPD.
- CALL_UPD (one cycle):
  - Drives wr_sp=1 with sp_l-4, wr_lr=1 with pc_l+4, wr_pc=1 with target_l, and done=1.
  - Next state is IDLE.
- POP:
  - Drives mem_re=1, mem_addr=sp_l.
  - On sampled mem_ready=1, latches mem_rdata and goes to RET_UPD.
- RET_UPD (one cycle):
  - Drives wr_pc=1 with lr_l, wr_lr=1 with the popped value, wr_sp=1 with sp_l+4, and done=1.
  - Next state is IDLE.
- Timeout:
  - The counter clears on entry to PUSH/POP and increments each cycle mem_ready=0.
  - At MEM_TIMEOUT cycles without ready, go to FAULT; no register writes occur.
- FAULT (one cycle): fault=1, all wr_* = 0, mem_we/mem_re = 0; next state is IDLE.
- Latency with zero-wait memory: request edge, then 1 memory cycle, then 1 update cycle. Registers commit at the end of the update cycle, and a new request is accepted on the following edge (3 edges request-to-request).
- Arithmetic: 32-bit modulo; no alignment check (the caller guarantees word alignment).
- Strobe rules:
  - The wr_* strobes are never high outside CALL_UPD/RET_UPD.
  - mem_we and mem_re are never high simultaneously.
  - done and fault are never high together.

Test Plan:
- CALL, zero-wait: pc=0x100, lr=0x44, sp=0x1000, target=0x200, mem_ready tied 1 -> PUSH writes 0x44 to 0xFFC; next cycle wr_sp=0xFFC, wr_lr=0x104, wr_pc=0x200, done=1; busy high for exactly 2 cycles.
- RET with 3 wait cycles: lr=0x104, sp=0xFFC, mem_rdata=0x44 on the 4th POP cycle -> mem_re held 4 cycles at addr 0xFFC; then wr_pc=0x104, wr_lr=0x44, wr_sp=0x1000, done=1.
- Overflow: CALL with sp=0x800 -> fault pulse one cycle after request; no mem_we, no wr_* strobes. Underflow: RET with sp=0x1000 -> fault, no mem_re.
- Timeout: CALL with mem_ready held 0 -> mem_we high for 16 cycles, then fault=1, no wr_*, returns to IDLE.
- call_req and ret_req asserted together with valid SP -> CALL sequence only. Requests pulsed while busy -> ignored, with no second done.
- Reset asserted mid-POP (asynchronously, between edges) -> mem_re, busy, and all wr_* drop to 0 immediately. After release, an idle cycle shows busy=0, and a fresh RET completes normally.
